mux_scan_sampler: RTL
=====================

// Module: mux_scan_sampler
// PURPOSE
//  Sequencer wrapped around the 4:1 gate-level multiplexer stage. Drives the
//  mux select pair, lets each channel settle, samples the mux output and
//  assembles the four channel bits into one 4-bit word. Delivers the word
//  downstream over a valid/ready handshake. Upstream of the mux select inputs
//  (sel[0] -> select LSB, sel[1] -> select MSB); downstream of the mux output.
// PARAMETERS
//  SETTLE_CYCLES  1  extra cycles each channel is held before sampling (0..15)
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  request a scan; accepted only as stated below
//  sel         out  2  mux select: sel[0]=LSB select, sel[1]=MSB select
//  mux_out     in   1  mux output, combinational from sel and data inputs
//  word        out  4  assembled word; word[n] = mux_out sampled with sel==n
//  word_valid  out  1  word is complete and stable
//  word_ready  in   1  consumer accepts word when word_valid&&word_ready
//  busy        out  1  high in SCAN and HOLD
//  word_parity out  1  only with MUX_SCAN_PARITY_EN
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset values: state=IDLE, sel=2'b00, word=4'h0, word_valid=0, busy=0,
//   word_parity=0. Reset mid-scan or in HOLD discards the partial/held word.
//  All outputs are registered; none depends combinationally on inputs.
//  FSM states IDLE, SCAN, HOLD:
//   IDLE: sel=0. start=1 at an edge -> SCAN, ch=0, settle cnt=0, busy=1.
//   SCAN: sel=ch. Each channel is held SETTLE_CYCLES+1 cycles; at the edge
//    ending its last cycle, word[ch]<=mux_out. ch<3: ch+1, cnt=0.
//    ch==3: -> HOLD, word_valid<=1, sel<=0.
//   HOLD: word and word_valid stable. word_ready=1 at an edge -> word_valid<=0;
//    if start=1 at that same edge -> SCAN (back-to-back, no IDLE cycle),
//    else -> IDLE, busy<=0.
//  start is ignored in SCAN, and in HOLD unless word_ready=1 at that edge.
//  Latency: start accepted at edge E0 -> word_valid high after edge
//   E0 + 4*(SETTLE_CYCLES+1) (S=1: 8 edges; S=0: 4 edges).
//  word bits not yet sampled in a new scan hold their previous values; only
//   the value presented with word_valid=1 is defined.
//  Counters: ch is 2 bits and never wraps past 3; cnt is 4 bits, no overflow
//   for legal SETTLE_CYCLES.
//  word_ready while word_valid=0 has no effect.
// CONFIGURATION
//  MUX_SCAN_PARITY_EN defined: port word_parity present; word_parity =
//   ^(completed word), updated at the same edge word_valid rises, held through
//   HOLD, cleared by reset only.
//  Not defined: port word_parity and its logic are absent; all else identical.
// TESTING
//  T1 reset: rst_n low mid-SCAN -> sel=0, word=0, word_valid=0, busy=0 at once.
//  T2 S=1, mux data = {ch3..ch0}=4'b1010, pulse start -> sel 0,0,1,1,2,2,3,3;
//     word_valid at edge 8; word=4'hA; parity=0 when MUX_SCAN_PARITY_EN set.
//  T3 S=0, data 4'b0111, word_ready held 0 for 5 cycles -> word stays 4'h7,
//     word_valid stays 1; ready=1 -> word_valid 0 next cycle, state IDLE.
//  T4 back-to-back: in HOLD assert word_ready=1 and start=1 together, data
//     changed to 4'h5 -> no IDLE cycle, second word 4'h5 after 4*(S+1) edges.
//  T5 start pulsed during SCAN -> ignored; exactly one word produced.
//  T6 data toggled after each channel's sample edge -> word holds the sampled
//     bits only (settle-window check, S=3: 16 edges to word_valid).

Source files
------------

// File: rtl/mux_scan_sampler.sv
// Scan sequencer for a 4:1 mux: steps the select, settles, samples, and
// hands the 4-bit word downstream. Optional MUX_SCAN_PARITY_EN adds word_parity.
module mux_scan_sampler #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] sel,
    input  logic       mux_out,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       word_parity
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 4'd0;
            sel_q    <= 2'd0;
            word_q   <= 4'h0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        word_d   = word_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    ch_d    = 2'd0;
                    cnt_d   = 4'd0;
                    sel_d   = 2'd0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_q == SETTLE) begin
                    // Last settle cycle of this channel: capture and advance.
                    word_d[ch_q] = mux_out;
                    cnt_d        = 4'd0;
                    if (ch_q == 2'd3) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
`ifdef MUX_SCAN_PARITY_EN
                        parity_d = ^word_d;
`endif
                    end else begin
                        ch_d  = ch_q + 2'd1;
                        sel_d = ch_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        // Back-to-back scan skips IDLE; busy stays high.
                        state_d = SCAN;
                        ch_d    = 2'd0;
                        cnt_d   = 4'd0;
                        sel_d   = 2'd0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                sel_d   = 2'd0;
            end
        endcase
    end

    assign sel        = sel_q;
    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
`ifdef MUX_SCAN_PARITY_EN
    assign word_parity = parity_q;
`endif

endmodule
